// File: rtl/gemm_tile_sequencer.sv
// Job sequencer for the fixed-weight systolic array: loads a weight tile, streams
// activations under FIFO credit, and captures results LATENCY cycles after issue.
module gemm_tile_sequencer #(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int LATENCY                = 8,
  parameter int OUT_FIFO_DEPTH         = 9,
  parameter int CNT_W                  = 16
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic [CNT_W-1:0]                          num_vectors,
  input  logic                                      wt_valid,
  output logic                                      wt_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] wt_data,
  input  logic                                      act_valid,
  output logic                                      act_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] act_data,
  output logic                                      sa_wt_we,
  output logic [$clog2(SA_SIZE)-1:0]                sa_wt_row,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_wt_data,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_act_data,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] sa_out_data,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] res_data,
  output logic                                      busy,
  output logic                                      done
);
  localparam int DW  = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int RW  = $clog2(SA_SIZE);
  localparam int PW  = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int IFW = $clog2(LATENCY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] popped_q, popped_d;
  logic [RW-1:0]    row_q, row_d;
  logic [LATENCY-1:0] pipe_q;
  logic [IFW-1:0]   inflight_q;
  logic [FCW-1:0]   fifo_cnt_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]    fifo_mem [OUT_FIFO_DEPTH];

  logic wt_fire, act_fire, push, pop, credit_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight_q)) < 32'(OUT_FIFO_DEPTH);
  assign wt_ready  = (state_q == S_LOAD_W);
  assign act_ready = (state_q == S_STREAM) && (issued_q < num_q) && credit_ok;
  assign wt_fire   = wt_valid && wt_ready;
  assign act_fire  = act_valid && act_ready;
  assign push      = pipe_q[LATENCY-1];
  assign res_valid = (fifo_cnt_q != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = fifo_mem[rd_ptr_q];

  assign sa_wt_we    = wt_fire;
  assign sa_wt_row   = row_q;
  assign sa_wt_data  = wt_data;
  assign sa_act_data = act_fire ? act_data : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    row_d    = row_q;
    issued_d = issued_q;
    popped_d = popped_q + CNT_W'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD_W;
          num_d    = num_vectors;
          row_d    = '0;
          issued_d = '0;
          popped_d = '0;
        end
      end
      S_LOAD_W: begin
        if (wt_fire) begin
          row_d = row_q + RW'(1);
          if (row_q == RW'(SA_SIZE - 1)) state_d = (num_q != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (act_fire) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_q + CNT_W'(1) == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (popped_d == num_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      row_q      <= '0;
      pipe_q     <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      row_q      <= row_d;
      pipe_q     <= {pipe_q[LATENCY-2:0], act_fire};
      inflight_q <= inflight_q + IFW'(act_fire) - IFW'(push);
      fifo_cnt_q <= fifo_cnt_q + FCW'(push) - FCW'(pop);
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= sa_out_data;
  end

endmodule
